muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Sequences the shared mult/div units and the HI/LO registers on behalf of ctrl_unit.
//   - Accepts one MULT/DIV request at a time and pulses the selected unit's start.
//   - Waits for the unit's end flag, then drives HILOCtrl/WriteHILO for exactly one write.
//   - Detects divide-by-zero and reports a cycle count for each op.
// PARAMETERS
//   WIDTH       32  operand width (divisor check)
//   CNT_W       6   op cycle counter width
//   MAX_CYCLES  40  watchdog limit in RUN states (used only with MULDIV_TIMEOUT_EN)
// PORTS
//   clk           in   1      system clock, rising edge
//   reset         in   1      asynchronous, active-low
//   op_req        in   1      request from ctrl_unit; sampled only in IDLE
//   op_sel        in   1      0 = MULT, 1 = DIV; sampled with op_req
//   divisor       in   WIDTH  B register value; sampled with op_req
//   op_busy       out  1      high in every state except IDLE
//   op_done       out  1      1-cycle pulse, coincident with hilo_we
//   div_zero_exc  out  1      1-cycle pulse; HI/LO untouched
//   timeout_err   out  1      1-cycle pulse (macro only, else constant 0)
//   mult_start    out  1      MultCtrl, 1-cycle pulse
//   div_start     out  1      DivCtrl, 1-cycle pulse
//   mult_end      in   1      mult unit finished
//   div_end       in   1      div unit finished
//   div_zero      in   1      div unit zero-divisor flag
//   hilo_sel      out  1      HILOCtrl: 0 = mult results, 1 = div results
//   hilo_we       out  1      WriteHILO
//   op_cycles     out  CNT_W  RUN-state cycle count, latched when op_done fires
// BEHAVIOUR
//   Outputs and reset
//   - All outputs registered. reset low: state=IDLE, every output and the counter = 0, immediately.
//   - Reset mid-op abandons the op; no HI/LO write follows.
//   States: IDLE, MRUN, DRUN, WB, EXC (plus ABORT with the macro).
//   IDLE
//   - op_req=1, op_sel=0: -> MRUN; mult_start=1 for the first MRUN cycle; hilo_sel<=0.
//   - op_req=1, op_sel=1, divisor!=0: -> DRUN; div_start=1 for the first DRUN cycle; hilo_sel<=1.
//   - op_req=1, op_sel=1, divisor==0: -> EXC; div_start never asserted.
//   - Accepting edge clears the counter.
//   MRUN
//   - Counter increments each cycle.
//   - mult_end=1: -> WB.
//   DRUN
//   - Counter increments each cycle.
//   - div_zero=1: -> EXC. div_zero wins over a simultaneous div_end.
//   - div_end=1 (div_zero=0): -> WB.
//   WB (1 cycle)
//   - hilo_we=1, op_done=1, op_cycles<=counter; -> IDLE.
//   EXC (1 cycle)
//   - div_zero_exc=1, hilo_we=0; -> IDLE.
//   Handshake and timing
//   - op_req while op_busy=1 is ignored, not queued.
//   - Earliest next accept is the cycle after op_done / div_zero_exc.
//   - Latency: end flag seen in cycle k of RUN -> WB in cycle k+1.
//   - hilo_sel holds its value after WB until the next accept.
//   - mult_end/div_end/div_zero are ignored in any state other than MRUN/DRUN respectively.
//   - Counter saturates at all-ones; no wrap.
// CONFIGURATION
//   MULDIV_TIMEOUT_EN defined
//   - Counter reaching MAX_CYCLES-1 in MRUN/DRUN with no end flag: -> ABORT.
//   - ABORT (1 cycle): timeout_err=1, no hilo_we, no start re-pulse; -> IDLE.
//   - An end flag in the same cycle as the limit wins (normal WB).
//   MULDIV_TIMEOUT_EN undefined
//   - No watchdog; RUN waits indefinitely; timeout_err tied 0.
// TESTING
//   T1 MULT, mult_end 33 cycles after accept, op_req held high throughout
//      -> mult_start high exactly 1 cycle; op_busy=1 until WB.
//      -> hilo_we = op_done = 1 for one cycle, hilo_sel=0, op_cycles=33.
//      -> Held op_req not re-accepted until the cycle after op_done.
//   T2 DIV, divisor=7, div_end after 32 cycles
//      -> div_start 1 pulse; hilo_sel=1; hilo_we 1 pulse; op_cycles=32.
//   T3 DIV, divisor=0
//      -> div_zero_exc 1 pulse in the cycle after accept.
//      -> div_start, hilo_we, op_done never asserted; op_busy back to 0 next cycle.
//   T4 DIV, divisor=5, unit raises div_zero and div_end in the same cycle
//      -> EXC taken; no HI/LO write.
//   T5 reset driven low asynchronously 10 cycles into MRUN
//      -> All outputs 0 before the next clk edge.
//      -> After release, new DIV request accepted normally.
//   T6 MULT, mult_end never asserted, MAX_CYCLES=40
//      -> Macro defined: timeout_err pulse at RUN cycle 40, then IDLE.
//      -> Macro undefined: op_busy stays 1 and op_cycles stays 0 for 100 cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Runs one MULT or DIV at a time on the shared units on behalf of ctrl_unit.
//   It pulses the selected unit's start, waits for that unit's end flag, and then
//   raises HILOCtrl/WriteHILO for exactly one HI/LO write. A zero divisor is
//   reported and nothing is written. Each completed op reports how many RUN
//   cycles it took.
//   Build macro MULDIV_TIMEOUT_EN: adds a RUN-state watchdog. When it fires,
//   the FSM goes through an ABORT state and pulses timeout_err. Without the
//   macro, RUN waits indefinitely and timeout_err is always 0.
`timescale 1ns/1ps
module muldiv_sequencer #(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 6,
    parameter int MAX_CYCLES = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_req,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] divisor,
    output logic             op_busy,
    output logic             op_done,
    output logic             div_zero_exc,
    output logic             timeout_err,
    output logic             mult_start,
    output logic             div_start,
    input  logic             mult_end,
    input  logic             div_end,
    input  logic             div_zero,
    output logic             hilo_sel,
    output logic             hilo_we,
    output logic [CNT_W-1:0] op_cycles
);

    // Handshake: op_req is a request qualified by ready = !op_busy. A request is
    // taken only on a clock edge where op_busy is low, and op_sel/divisor are
    // captured on that same edge. A request made while op_busy is high is
    // dropped, not queued. The first edge that can accept again is the one
    // that ends the cycle after op_done/div_zero_exc/timeout_err.

    // The watchdog limit must be a value that the op cycle counter can reach.
    if (MAX_CYCLES < 2 || MAX_CYCLES > (1 << CNT_W)) begin : gBadLimit
        $error("MAX_CYCLES must lie within the op cycle counter range");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MRUN  = 3'd1,
        DRUN  = 3'd2,
        WB    = 3'd3,
`ifdef MULDIV_TIMEOUT_EN
        EXC   = 3'd4,
        ABORT = 3'd5
`else
        EXC   = 3'd4
`endif
    } seqState_t;

    // Internal state signal; checkers can bind to it by name.
    seqState_t        state;
    logic [CNT_W-1:0] opCount;
    logic [CNT_W-1:0] cntNext;

    // Saturating increment; the counter holds at all-ones and never wraps.
    assign cntNext = (opCount == '1) ? opCount : opCount + CNT_W'(1);

`ifdef MULDIV_TIMEOUT_EN
    logic limitHit;
    // Fires in the RUN cycle whose count has reached MAX_CYCLES-1.
    assign limitHit = (opCount == CNT_W'(MAX_CYCLES - 1));
`endif

    // Sequencer FSM. Every output is registered, so a state's outputs are set on
    // the edge that enters that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            opCount      <= '0;
            op_busy      <= 1'b0;
            op_done      <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_err  <= 1'b0;
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            hilo_sel     <= 1'b0;
            hilo_we      <= 1'b0;
            op_cycles    <= '0;
        end else begin
            op_done      <= 1'b0;
            div_zero_exc <= 1'b0;
            timeout_err  <= 1'b0;
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            hilo_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_req) begin
                        opCount <= '0;
                        op_busy <= 1'b1;
                        if (!op_sel) begin
                            state      <= MRUN;
                            mult_start <= 1'b1;
                            hilo_sel   <= 1'b0;
                        end else if (divisor != '0) begin
                            state     <= DRUN;
                            div_start <= 1'b1;
                            hilo_sel  <= 1'b1;
                        end else begin
                            // The divide unit is never started for a zero divisor.
                            state        <= EXC;
                            div_zero_exc <= 1'b1;
                        end
                    end
                end
                MRUN: begin
                    opCount <= cntNext;
                    if (mult_end) begin
                        state     <= WB;
                        hilo_we   <= 1'b1;
                        op_done   <= 1'b1;
                        op_cycles <= cntNext;
`ifdef MULDIV_TIMEOUT_EN
                    end else if (limitHit) begin
                        state       <= ABORT;
                        timeout_err <= 1'b1;
`endif
                    end
                end
                DRUN: begin
                    opCount <= cntNext;
                    // A zero-divisor flag beats an end flag raised in the same cycle.
                    if (div_zero) begin
                        state        <= EXC;
                        div_zero_exc <= 1'b1;
                    end else if (div_end) begin
                        state     <= WB;
                        hilo_we   <= 1'b1;
                        op_done   <= 1'b1;
                        op_cycles <= cntNext;
`ifdef MULDIV_TIMEOUT_EN
                    end else if (limitHit) begin
                        state       <= ABORT;
                        timeout_err <= 1'b1;
`endif
                    end
                end
                WB, EXC: begin
                    state   <= IDLE;
                    op_busy <= 1'b0;
                end
`ifdef MULDIV_TIMEOUT_EN
                ABORT: begin
                    state   <= IDLE;
                    op_busy <= 1'b0;
                end
`endif
                default: begin
                    state   <= IDLE;
                    op_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed and randomized ops against a timeline model. For each op, the model
//   predicts from the op's parameters which cycle shows each pulse, when busy
//   drops, and what the HI/LO select and cycle report must be.
//   Build macro MULDIV_TIMEOUT_EN selects the watchdog expectations.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    localparam int WIDTH      = 32;
    localparam int CNT_W      = 6;
    localparam int MAX_CYCLES = 40;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;
`ifdef MULDIV_TIMEOUT_EN
    localparam int K_MAX = MAX_CYCLES;
`else
    localparam int K_MAX = 70;
`endif

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             op_req = 1'b0;
    logic             op_sel = 1'b0;
    logic [WIDTH-1:0] divisor = '0;
    logic             mult_end = 1'b0;
    logic             div_end = 1'b0;
    logic             div_zero = 1'b0;
    logic             op_busy, op_done, div_zero_exc, timeout_err;
    logic             mult_start, div_start, hilo_sel, hilo_we;
    logic [CNT_W-1:0] op_cycles;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .op_req(op_req), .op_sel(op_sel), .divisor(divisor),
        .op_busy(op_busy), .op_done(op_done), .div_zero_exc(div_zero_exc),
        .timeout_err(timeout_err), .mult_start(mult_start), .div_start(div_start),
        .mult_end(mult_end), .div_end(div_end), .div_zero(div_zero),
        .hilo_sel(hilo_sel), .hilo_we(hilo_we), .op_cycles(op_cycles)
    );

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    logic             expSel = 1'b0;
    logic [CNT_W-1:0] expCycles = '0;
    logic [CNT_W-1:0] expQ[$];

    function automatic logic [CNT_W-1:0] satCount(input int k);
        return (k > CNT_SAT) ? CNT_W'(CNT_SAT) : CNT_W'(k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compares every output. The select and cycle-report values come from the model.
    task automatic checkAll(input string tag, input logic busy, input logic done,
                            input logic exc, input logic terr, input logic mst,
                            input logic dst, input logic we);
        chkBit({tag, ".busy"}, op_busy, busy);
        chkBit({tag, ".done"}, op_done, done);
        chkBit({tag, ".exc"}, div_zero_exc, exc);
        chkBit({tag, ".terr"}, timeout_err, terr);
        chkBit({tag, ".mstart"}, mult_start, mst);
        chkBit({tag, ".dstart"}, div_start, dst);
        chkBit({tag, ".we"}, hilo_we, we);
        chkBit({tag, ".sel"}, hilo_sel, expSel);
        chkInt({tag, ".cycles"}, int'(op_cycles), int'(expCycles));
    endtask

    // ---------------- driver ----------------
    // One op: the unit flag arrives in RUN cycle k. The op ends in a HI/LO write,
    // or in an exception when the divisor is 0 or when div_zero comes with the end flag.
    task automatic runOp(input string tag, input logic sel, input logic [WIDTH-1:0] dv,
                         input int k, input logic zeroAtEnd, input logic holdReq);
        logic isExc;
        logic excAtEnd;
        isExc    = sel && (dv == '0);
        excAtEnd = sel && zeroAtEnd;
        op_req = 1'b1; op_sel = sel; divisor = dv;
        {mult_end, div_end, div_zero} = 3'($urandom);
        if (!isExc) begin
            expSel = sel;
            if (!excAtEnd) expQ.push_back(satCount(k));
        end
        step();
        if (!holdReq) begin
            op_req = 1'b0; op_sel = 1'($urandom); divisor = $urandom;
        end
        if (isExc) begin
            checkAll({tag, ".exc"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            {mult_end, div_end, div_zero} = 3'($urandom);
            step();
            checkAll({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        for (int t = 0; t < k; t++) begin
            checkAll({tag, ".run"}, 1'b1, 1'b0, 1'b0, 1'b0, (t == 0) && !sel, (t == 0) && sel, 1'b0);
            if (sel) begin
                mult_end = 1'($urandom);
                div_end  = (t == k - 1);
                div_zero = (t == k - 1) && zeroAtEnd;
            end else begin
                mult_end = (t == k - 1);
                div_end  = 1'($urandom);
                div_zero = 1'($urandom);
            end
            step();
        end
        if (excAtEnd) begin
            checkAll({tag, ".excend"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            expCycles = expQ.pop_front();
            checkAll({tag, ".wb"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        {mult_end, div_end, div_zero} = 3'($urandom);
        step();
        checkAll({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (holdReq) begin
            // The request that was held through WB is taken now, not earlier.
            mult_end = 1'b0;
            step();
            checkAll({tag, ".reaccept"}, 1'b1, 1'b0, 1'b0, 1'b0, !sel, sel, 1'b0);
            op_req = 1'b0;
            expQ.push_back(satCount(1));
            if (sel) div_end = 1'b1; else mult_end = 1'b1;
            div_zero = 1'b0;
            step();
            expCycles = expQ.pop_front();
            checkAll({tag, ".wb2"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            {mult_end, div_end, div_zero} = 3'b000;
            step();
            checkAll({tag, ".idle2"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idleGap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            op_req = 1'b0;
            {mult_end, div_end, div_zero} = 3'($urandom);
            step();
            checkAll(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        #3;
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        idleGap("idle0", 3);

        runOp("t1", 1'b0, '0, 33, 1'b0, 1'b1);
        runOp("t2", 1'b1, 32'd7, 32, 1'b0, 1'b0);
        runOp("t3", 1'b1, '0, 0, 1'b0, 1'b0);
        idleGap("selhold", 1);
        runOp("t4", 1'b1, 32'd5, 7, 1'b1, 1'b0);
        runOp("kmin", 1'b0, '0, 1, 1'b0, 1'b0);
        runOp("kmax", 1'b1, 32'd3, K_MAX, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic             s;
            logic [WIDTH-1:0] d;
            s = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            runOp("rnd", s, d, $urandom_range(1, K_MAX), ($urandom_range(0, 3) == 0), 1'b0);
            idleGap("rgap", $urandom_range(0, 3));
        end

        // T5: asynchronous reset in the middle of a MULT
        op_req = 1'b1; op_sel = 1'b0; {mult_end, div_end, div_zero} = 3'b000;
        expSel = 1'b0;
        step();
        op_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checkAll("t5.run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        expSel = 1'b0; expCycles = '0;
        checkAll("t5.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mult_end = 1'b1;
        step();
        checkAll("t5.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mult_end = 1'b0;
        #2 reset = 1'b1;
        step();
        checkAll("t5.release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runOp("t5.div", 1'b1, 32'd9, 5, 1'b0, 1'b0);

        // T6: a MULT whose end flag never comes, started from a fresh reset
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        expSel = 1'b0; expCycles = '0;
        step();
        op_req = 1'b1; op_sel = 1'b0; {mult_end, div_end, div_zero} = 3'b000;
        step();
        op_req = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        for (int t = 0; t < MAX_CYCLES; t++) begin
            checkAll("t6.run", 1'b1, 1'b0, 1'b0, 1'b0, t == 0, 1'b0, 1'b0);
            div_end = 1'($urandom);
            step();
        end
        checkAll("t6.abort", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checkAll("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        for (int t = 0; t < 100; t++) begin
            checkAll("t6.run", 1'b1, 1'b0, 1'b0, 1'b0, t == 0, 1'b0, 1'b0);
            div_end = 1'($urandom);
            step();
        end
        // The count has saturated by now; a late end flag reports all-ones.
        expQ.push_back(satCount(101));
        mult_end = 1'b1;
        step();
        expCycles = expQ.pop_front();
        checkAll("t6.satwb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mult_end = 1'b0;
        step();
        checkAll("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        chkInt("scoreboard.empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
